shift_sequencer: RTL and testbench

//  Multi-cycle shift unit for the processor datapath. It reuses a single 1-bit shift

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 23 ++
 rtl/shift_sequencer.sv | 84 ++++++++
 tb/tb_shift_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer and its 1-bit step stage.
package shift_pkg;

  // Operation encodings as seen on the op port.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift stage: applies a single shift/rotate step of the selected kind.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  shift_op_e         op,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  // Select the single-step transform for the current operation.
  always_comb begin
    unique case (op)
      OP_SLL: dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL: dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROL: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts an operation, performs one 1-bit step per clock
// through a shared shift_step stage, and returns the result via valid/ready.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  state_e             state, state_next;
  shift_op_e          op_q;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   step_out;
  logic               accept;

  assign accept = (state == S_IDLE) && start_valid;

  // Single shared step stage in the shift-register feedback path.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (shift_q),
    .dout (step_out)
  );

  // State register; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start_valid) state_next = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (count == SHAMT_W'(1)) state_next = S_DONE;
      S_DONE:  if (result_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; no overlap of result and new start.
  always_comb begin
    start_ready  = (state == S_IDLE);
    result_valid = (state == S_DONE);
    busy         = (state != S_IDLE);
  end

  // Datapath: capture operands on accept, step once per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count   <= '0;
      op_q    <= OP_SLL;
    end else if (accept) begin
      shift_q <= operand;
      count   <= shamt;
      op_q    <= shift_op_e'(op);
    end else if (state == S_SHIFT) begin
      shift_q <= step_out;
      count   <= count - SHAMT_W'(1);
    end
  end

  assign result = shift_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table of directed operations plus
// hand-written backpressure and mid-operation reset sequences.
module tb_shift_sequencer;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] ROL = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_valid;
  logic               start_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               result_valid;
  logic               result_ready;
  logic [WIDTH-1:0]   result;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string              name;
    logic [1:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   expected;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .operand      (operand),
    .shamt        (shamt),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (bounded) for result_valid; returns cycles counted since the accept edge.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!result_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Issue one operation, scramble the inputs after accept, check latency and result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] v,
                        input logic [4:0] s, input logic [31:0] exp);
    int cyc;
    cyc = 0;
    while (!start_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " start_ready"}, 32'(start_ready), 32'd1);
    op = o; operand = v; shamt = s; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; op = ~o; operand = ~v; shamt = ~s;
    check({name, " busy"}, 32'(busy), 32'd1);
    wait_valid(cyc);
    check({name, " latency"}, 32'(cyc), 32'(s) + 32'd1);
    check({name, " result"}, result, exp);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({name, " back_idle"}, {30'd0, start_ready, result_valid}, 32'h2);
    check({name, " hold"}, result, exp);
  endtask

  initial begin
    int cyc;

    vecs = '{
      '{"sll_by2",     SLL, 32'h12345678, 5'd2,  32'h48D159E0},
      '{"sra_by31",    SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF},
      '{"srl_by31",    SRL, 32'h80000000, 5'd31, 32'h00000001},
      '{"sll_by0",     SLL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF},
      '{"rol_by1",     ROL, 32'h80000001, 5'd1,  32'h00000003},
      '{"rol_by31",    ROL, 32'h00000001, 5'd31, 32'h80000000},
      '{"sra_pos_by4", SRA, 32'h7FFFFFFF, 5'd4,  32'h07FFFFFF},
      '{"sra_neg_by8", SRA, 32'hF0000000, 5'd8,  32'hFFF00000},
      '{"rol_by4",     ROL, 32'hA5A5A5A5, 5'd4,  32'h5A5A5A5A},
      '{"sll_by31",    SLL, 32'h00000001, 5'd31, 32'h80000000},
      '{"srl_by0",     SRL, 32'h0000ABCD, 5'd0,  32'h0000ABCD}
    };

    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    op = SLL; operand = '0; shamt = '0;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset flags", {29'd0, start_ready, result_valid, busy}, 32'h4);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].expected);

    // Backpressure: hold result_ready low for 5 cycles with a competing start request.
    op = SLL; operand = 32'h1; shamt = 5'd3; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    wait_valid(cyc);
    check("bp latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; op = SRL; operand = 32'hF0; shamt = 5'd4;
      check("bp result", result, 32'h8);
      check("bp flags", {29'd0, start_ready, result_valid, busy}, 32'h3);
      @(negedge clk);
    end
    check("bp still valid", {31'd0, result_valid}, 32'h1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp idle gap", {29'd0, start_ready, result_valid, busy}, 32'h4);
    check("bp idle hold", result, 32'h8);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp accepted", 32'(busy), 32'd1);
    wait_valid(cyc);
    check("bp next latency", 32'(cyc), 32'd5);
    check("bp next result", result, 32'h0000000F);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;

    // Reset while SLL by 20 is mid-SHIFT, seven cycles after accept.
    op = SLL; operand = 32'h1; shamt = 5'd20; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid busy before rst", {30'd0, busy, result_valid}, 32'h2);
    rst = 1'b1;
    #1;
    check("rst result", result, 32'h0);
    check("rst flags", {30'd0, result_valid, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post rst ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    run_op("post rst srl", SRL, 32'h000000F0, 5'd4, 32'h0000000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
